// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1,
      DROP  = 2'd2
   } fetch_state_e;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
   localparam logic [31:0] PC_INC    = 32'd4;

   // Instruction addresses are word aligned; low two bits are always cleared.
   function automatic logic [31:0] align_pc(input logic [31:0] pc);
      return {pc[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_perf.sv
// Free-running performance counters for the fetch stage.
// Only instantiated when FETCH_PERF_EN is defined.
module fetch_perf (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        stall_cycle,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_stall_cycles
);

   logic [31:0] fetched_q, fetched_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   // Counters wrap naturally at 2^32.
   always_comb begin
      fetched_d   = fetched_q;
      stall_cnt_d = stall_cnt_q;
      if (load) begin
         fetched_d = fetched_q + 32'd1;
      end
      if (stall_cycle) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   // Counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetched_q   <= 32'd0;
         stall_cnt_q <= 32'd0;
      end else begin
         fetched_q   <= fetched_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign perf_fetched      = fetched_q;
   assign perf_stall_cycles = stall_cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps one memory read outstanding at
// a time and presents returned words to the fetch/decode register.
// Optional build macro FETCH_PERF_EN adds perf_fetched / perf_stall_cycles.
//
// state | meaning
// ------+-----------------------------------------------------------
// FETCH | no request outstanding; may issue a read at pc
// WAIT  | one read outstanding; its data will be presented
// DROP  | one read outstanding whose data is discarded (after redirect)
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rdy,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] Fe_out_PC_next,
   output logic [31:0] Fe_out_instr,
   output logic        Fe_out_valid,
`ifdef FETCH_PERF_EN
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_stall_cycles,
`endif
   output logic        flush
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  instr_q, instr_d;
   logic [31:0]  pc_next_q, pc_next_d;
   logic         valid_q, valid_d;
   logic         flush_q, flush_d;
   logic         accept;
   logic [31:0]  pc_inc;

   assign pc_inc = pc_q + PC_INC;

   // A held (stalled) instruction blocks new requests so the output slot is
   // guaranteed empty by the time any response returns.
   assign imem_req  = rst_n & (state_q == FETCH) & ~(valid_q & stall);
   assign imem_addr = pc_q;
   assign accept    = imem_req & imem_rdy;

   // Next-state, PC and output-register computation; redirect overrides all.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      pc_next_d = pc_next_q;
      valid_d   = valid_q;
      flush_d   = 1'b0;

      if (valid_q && !stall) begin
         valid_d = 1'b0;
         instr_d = NOP_INSTR;
      end

      case (state_q)
         FETCH: begin
            if (accept) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (imem_rvalid) begin
               state_d   = FETCH;
               instr_d   = imem_rdata;
               pc_next_d = pc_inc;
               valid_d   = 1'b1;
               pc_d      = pc_inc;
            end
         end
         DROP: begin
            if (imem_rvalid) begin
               state_d = FETCH;
            end
         end
         default: state_d = FETCH;
      endcase

      if (redirect) begin
         pc_d      = align_pc(redirect_pc);
         pc_next_d = pc_next_q;
         valid_d   = 1'b0;
         instr_d   = NOP_INSTR;
         flush_d   = 1'b1;
         case (state_q)
            FETCH:   state_d = accept ? DROP : FETCH;
            // A response arriving with the redirect retires the outstanding
            // read, so there is nothing left to drop.
            default: state_d = imem_rvalid ? FETCH : DROP;
         endcase
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= FETCH;
         pc_q      <= RESET_PC;
         instr_q   <= NOP_INSTR;
         pc_next_q <= 32'd0;
         valid_q   <= 1'b0;
         flush_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         pc_next_q <= pc_next_d;
         valid_q   <= valid_d;
         flush_q   <= flush_d;
      end
   end

   assign Fe_out_PC_next = pc_next_q;
   assign Fe_out_instr   = instr_q;
   assign Fe_out_valid   = valid_q;
   assign flush          = flush_q;

`ifdef FETCH_PERF_EN
   logic load;
   logic stall_cycle;

   assign load        = (state_q == WAIT) & imem_rvalid & ~redirect;
   assign stall_cycle = valid_q & stall;

   fetch_perf u_perf (
      .clk               (clk),
      .rst_n             (rst_n),
      .load              (load),
      .stall_cycle       (stall_cycle),
      .perf_fetched      (perf_fetched),
      .perf_stall_cycles (perf_stall_cycles)
   );
`endif

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the CPU pipeline, directly upstream of the fetch/decode pipeline register. Owns the program counter, issues single-outstanding read requests to instruction memory, and presents each returned instruction with its PC+4 to the fetch/decode register. Honours pipeline stalls and redirects from later stages, and emits the flush pulse that bubbles the fetch/decode register.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- stall  input  1  hazard stall: hold presented instruction, issue no new request.
- redirect  input  1  taken branch/jump from a later stage.
- redirect_pc  input  32  target; bits [1:0] forced to 0.
- imem_req  output  1  read request.
- imem_addr  output  32  request address (= pc).
- imem_rdy  input  1  memory accepts request this cycle when imem_req=1.
- imem_rvalid  input  1  read data valid, at least one cycle after acceptance.
- imem_rdata  input  32  instruction word.
- Fe_out_PC_next  output  32  PC of presented instruction + 4.
- Fe_out_instr  output  32  presented instruction; NOP_INSTR (32'h0) when invalid.
- Fe_out_valid  output  1  presented instruction is real.
- flush  output  1  one-cycle pulse to clear the fetch/decode register.

## Operation
- States: FETCH (may request), WAIT (one request outstanding), DROP (outstanding response to be discarded).
- Reset (rst_n=0 at edge): pc=RESET_PC, state=FETCH, Fe_out_instr=0, Fe_out_PC_next=0, Fe_out_valid=0, flush=0. imem_req=0 combinationally while rst_n=0.
- FETCH: imem_req = !(Fe_out_valid & stall). Accepted (imem_req & imem_rdy) -> WAIT. Else stay.
- WAIT on imem_rvalid: Fe_out_instr<=imem_rdata, Fe_out_PC_next<=pc+4, Fe_out_valid<=1, pc<=pc+4, -> FETCH.
- Output register: if Fe_out_valid & !stall and nothing loads, Fe_out_valid<=0, Fe_out_instr<=0 (consumed). If stall, outputs hold.
- Single outstanding request guarantees output slot is empty when a response arrives.
- Redirect (highest priority, overrides stall and rvalid): pc<=redirect_pc & ~3, Fe_out_valid<=0, Fe_out_instr<=0, flush<=1 next cycle. Next state: DROP if in WAIT or request accepted this cycle in FETCH (rvalid arriving same cycle in WAIT is discarded -> FETCH instead); else FETCH.
- DROP: on rvalid discard data -> FETCH; redirect in DROP updates pc, stays DROP.
- PC arithmetic modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- Request accepted cycle N, rvalid cycle N+k (k>=1), outputs visible N+k+1.
- Peak throughput one instruction per 2 cycles (k=1).
- flush high exactly one cycle, the cycle after redirect sampled; back-to-back redirects give consecutive flush cycles.
- imem_addr/imem_req combinational from state and pc; no input-to-output combinational path except stall -> imem_req.

## Configuration
- FETCH_PERF_EN defined: adds outputs perf_fetched (32, count of instructions loaded to output register) and perf_stall_cycles (32, cycles with Fe_out_valid & stall); both reset to 0, wrap at 2^32.
- Undefined: ports and counters absent; all other behaviour identical.

## Structure
- fetch_pkg: state enum (FETCH, WAIT, DROP), NOP_INSTR = 32'h0, PC_INC = 4.
- Sub-module fetch_perf holds the counters, instantiated only under FETCH_PERF_EN.

## Test plan
- Reset with RESET_PC=32'h100, rdy=1, 1-cycle memory -> imem_addr 0x100, 0x104, 0x108 on alternating cycles; Fe_out_PC_next 0x104, 0x108, 0x10C with matching instr.
- Stall held 3 cycles while Fe_out_valid=1 -> instr/PC_next stable, imem_req=0; release -> next request issued.
- Redirect to 0x203 while in WAIT, rvalid two cycles later with 0xDEADBEEF -> flush pulses once, data discarded, next imem_addr=0x200.
- Redirect to 0x400 same cycle as rvalid -> Fe_out_valid stays 0, state FETCH, imem_addr=0x400 next cycle.
- imem_rdy low 4 cycles -> imem_req and imem_addr held steady, no output change.
- pc=0xFFFF_FFFC fetch -> Fe_out_PC_next=0, next imem_addr=0; with FETCH_PERF_EN, perf_fetched increments per load.
